// File: rtl/alu_pkg.sv
// Opcode encodings and FSM state type shared by the sequential ALU and its bench.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLTU  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLL   = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRL   = 4'b1001;
  localparam logic [OP_W-1:0] OP_SRA   = 4'b1010;
  localparam logic [OP_W-1:0] OP_MULTU = 4'b1100;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Shared iterative engine: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// done_c flags the final iteration; lo_c/hi_c carry that iteration's result so it can be captured on the same edge.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] hi_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             r_busy;
  logic             r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shl;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_q_nx;

  // One iteration: {acc,q} is the product/remainder-quotient shift pair.
  always_comb begin
    w_add    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    w_shl    = {r_acc, r_q[WIDTH-1]};
    w_ge     = (w_shl >= {1'b0, r_m});
    w_sub    = w_shl[WIDTH-1:0] - r_m;
    w_acc_nx = w_add[WIDTH:1];
    w_q_nx   = {w_add[0], r_q[WIDTH-1:1]};
    if (r_div) begin
      w_acc_nx = w_ge ? w_sub : w_shl[WIDTH-1:0];
      w_q_nx   = {r_q[WIDTH-2:0], w_ge};
    end
  end

  assign busy   = r_busy;
  assign done_c = r_busy & (r_cnt == CNT_W'(WIDTH - 1));
  assign lo_c   = w_q_nx;
  assign hi_c   = w_acc_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_m    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_div  <= is_div;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= a;
      r_m    <= b;
    end else if (r_busy) begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt + CNT_W'(1);
      if (done_c) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MULTU/DIVU,
// with valid/ready handshakes on both the operand and the result side.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             div0
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_t r_state;
  state_t w_state_nx;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_div0;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_load_single;
  logic             w_load_iter;
  logic             w_md_start;
  logic             w_md_is_div;
  logic             w_md_busy;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;

  logic             w_is_sub;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic [SH_W-1:0]  w_sh;
  logic             w_slt;
  logic             w_sltu;
  logic             w_ovf;
  logic             w_div0;
  logic [WIDTH-1:0] w_y1;

  // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
  assign w_is_sub    = (op == OP_SUB);
  assign w_b_zero    = (b == '0);
  assign w_bx        = w_is_sub ? ~b : b;
  assign w_sum       = a + w_bx + {{(WIDTH-1){1'b0}}, w_is_sub};
  assign w_sh        = b[SH_W-1:0];
  assign w_slt       = ($signed(a) < $signed(b));
  assign w_sltu      = (a < b);
  assign w_ovf       = ((op == OP_ADD) | w_is_sub) &
                       (a[WIDTH-1] == w_bx[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_div0      = (op == OP_DIVU) & w_b_zero;
  assign w_md_is_div = (op == OP_DIVU);

  always_comb begin
    w_y1 = '0;
    case (op)
      OP_AND:  w_y1 = a & b;
      OP_OR:   w_y1 = a | b;
      OP_ADD:  w_y1 = w_sum;
      OP_SUB:  w_y1 = w_sum;
      OP_SLT:  w_y1 = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU: w_y1 = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_SLL:  w_y1 = a << w_sh;
      OP_SRL:  w_y1 = a >> w_sh;
      OP_SRA:  w_y1 = $unsigned($signed(a) >>> w_sh);
      OP_DIVU: w_y1 = '1;
      default: w_y1 = '0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_md_start),
    .is_div  (w_md_is_div),
    .a       (a),
    .b       (b),
    .busy    (w_md_busy),
    .done_c  (w_md_done),
    .lo_c    (w_md_lo),
    .hi_c    (w_md_hi)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next state; an accept overrides the DONE->IDLE exit for back-to-back issue.
  always_comb begin
    w_state_nx    = r_state;
    w_in_ready    = 1'b0;
    w_accept      = 1'b0;
    w_load_single = 1'b0;
    w_load_iter   = 1'b0;
    w_md_start    = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_state_nx = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (!w_md_busy) begin
          w_state_nx = ST_IDLE;
        end else if (w_md_done) begin
          w_state_nx  = ST_DONE;
          w_load_iter = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_accept = in_valid & w_in_ready;
    if (w_accept) begin
      if (op == OP_MULTU) begin
        w_state_nx = ST_MUL;
        w_md_start = 1'b1;
      end else if ((op == OP_DIVU) && !w_b_zero) begin
        w_state_nx = ST_DIV;
        w_md_start = 1'b1;
      end else begin
        w_state_nx    = ST_DONE;
        w_load_single = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_hi        <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_div0      <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nx == ST_DONE);
      if (w_load_single) begin
        r_y    <= w_y1;
        r_hi   <= w_div0 ? a : '0;
        r_zero <= (w_y1 == '0);
        r_ovf  <= w_ovf;
        r_div0 <= w_div0;
      end else if (w_load_iter) begin
        r_y    <= w_md_lo;
        r_hi   <= w_md_hi;
        r_zero <= (w_md_lo == '0);
        r_ovf  <= 1'b0;
        r_div0 <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign hi        = r_hi;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign div0      = r_div0;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomised bench for alu_seq (WIDTH=32) with a result scoreboard.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] y;
  logic [W-1:0] hi;
  logic         zero;
  logic         ovf;
  logic         div0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .hi        (hi),
    .zero      (zero),
    .ovf       (ovf),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        tag;
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         div0;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [W-1:0] yv, input logic [W-1:0] hv,
                              input logic z, input logic o, input logic d, input int lat);
    exp_t e;
    e.tag = tag; e.y = yv; e.hi = hv; e.zero = z; e.ovf = o; e.div0 = d; e.lat = lat;
    return e;
  endfunction

  // Reference behaviour written from the opcode table.
  function automatic exp_t model(input string tag, input logic [3:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] v);
    exp_t e;
    logic [2*W-1:0] p;
    logic [W-1:0]   s;
    e.tag = tag; e.y = '0; e.hi = '0; e.ovf = 1'b0; e.div0 = 1'b0; e.lat = 1;
    case (o)
      OP_AND:  e.y = x & v;
      OP_OR:   e.y = x | v;
      OP_ADD:  begin s = x + v; e.y = s; e.ovf = (x[W-1] == v[W-1]) && (s[W-1] != x[W-1]); end
      OP_SUB:  begin s = x - v; e.y = s; e.ovf = (x[W-1] != v[W-1]) && (s[W-1] != x[W-1]); end
      OP_SLT:  e.y = ($signed(x) < $signed(v)) ? 32'd1 : 32'd0;
      OP_SLTU: e.y = (x < v) ? 32'd1 : 32'd0;
      OP_SLL:  e.y = x << v[4:0];
      OP_SRL:  e.y = x >> v[4:0];
      OP_SRA:  e.y = $unsigned($signed(x) >>> v[4:0]);
      OP_MULTU: begin
        p = {32'd0, x} * {32'd0, v};
        e.y = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      OP_DIVU: begin
        if (v == '0) begin e.y = '1; e.hi = x; e.div0 = 1'b1; end
        else begin e.y = x / v; e.hi = x % v; e.lat = 33; end
      end
      default: e.y = '0;
    endcase
    e.zero = (e.y == '0);
    return e;
  endfunction

  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] v, input exp_t e);
    op = o; a = x; b = v; in_valid = 1'b1;
    sb.push_back(e);
    #1;
    chk({"in_ready_", e.tag}, W'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'b0100;
  endtask

  task automatic recv(input bit hs);
    exp_t e;
    int   g;
    chk("sb_nonempty", W'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    last = e;
    g = 0;
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk({"lat_", e.tag},  W'(cyc - acc_cyc + 1), W'(e.lat));
    chk({"vld_", e.tag},  W'(out_valid), 32'd1);
    chk({"y_", e.tag},    y, e.y);
    chk({"hi_", e.tag},   hi, e.hi);
    chk({"zero_", e.tag}, W'(zero), W'(e.zero));
    chk({"ovf_", e.tag},  W'(ovf), W'(e.ovf));
    chk({"div0_", e.tag}, W'(div0), W'(e.div0));
    if (hs) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [3:0]   ops[11];
    logic [W-1:0] rx;
    logic [W-1:0] rv;
    int           seen;

    #1;
    chk("rst_valid", W'(out_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_flags", W'({zero, ovf, div0}), 32'd0);
    chk("rst_in_ready", W'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, mk("add_ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1));
    recv(1);
    send(OP_SUB, 32'd5, 32'd5, mk("sub_zero", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1));
    recv(1);
    send(OP_SLT, 32'h8000_0000, 32'd1, mk("slt", 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1));
    recv(1);
    send(OP_SLTU, 32'h8000_0000, 32'd1, mk("sltu", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1));
    recv(1);
    send(OP_SRA, 32'h8000_0000, 32'd4, mk("sra", 32'hF800_0000, 32'd0, 1'b0, 1'b0, 1'b0, 1));
    recv(1);
    send(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
         mk("mul_max", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33));
    recv(1);

    // Requests presented while dividing must be ignored.
    send(OP_DIVU, 32'd100, 32'd7, mk("div_100_7", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      #1;
      chk("busy_in_ready", W'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    recv(1);
    @(negedge clk);
    chk("no_extra_out", W'(out_valid), 32'd0);

    send(OP_DIVU, 32'd9, 32'd0, mk("div_by0", 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b1, 1));
    recv(1);

    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_MULTU, OP_DIVU, 4'b1111};
    for (int i = 0; i < 11; i++) begin
      rx = $urandom;
      rv = (ops[i] == OP_DIVU) ? W'($urandom_range(1, 5000)) : W'($urandom);
      send(ops[i], rx, rv, model($sformatf("rnd%0d", i), ops[i], rx, rv));
      recv(1);
    end

    send(OP_OR, 32'h0000_00F0, 32'h0000_0F00, mk("hold", 32'h0000_0FF0, 32'd0, 1'b0, 1'b0, 1'b0, 1));
    recv(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", W'(out_valid), 32'd1);
      chk("hold_y", y, last.y);
      chk("hold_hi", hi, last.hi);
      chk("hold_in_ready", W'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(OP_ADD, 32'h10, 32'h20, mk("b2b", 32'h30, 32'd0, 1'b0, 1'b0, 1'b0, 1));
    out_ready = 1'b0;
    recv(1);

    // Reset mid-multiply: outputs clear at once and no result ever appears.
    send(OP_MULTU, 32'd3, 32'd5, mk("mul_abort", 32'd15, 32'd0, 1'b0, 1'b0, 1'b0, 33));
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_valid", W'(out_valid), 32'd0);
    chk("abort_y", y, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_flags", W'({zero, ovf, div0}), 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort_in_ready", W'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_out", W'(seen), 32'd0);
    send(OP_ADD, 32'd2, 32'd3, mk("add_after_rst", 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1));
    recv(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
